// File: rtl/tv80_reg_dma_if.sv
// Port bundle between the TV80 register-file DMA engine and its surroundings.
// The slave modport is the DMA engine; the master modport drives it.
interface tv80_reg_dma_if;
    logic        cpu_cen;
    logic        cpu_weh;
    logic        cpu_wel;
    logic [2:0]  cpu_addra;
    logic [7:0]  cpu_dih;
    logic [7:0]  cpu_dil;

    logic        rf_cen;
    logic        rf_weh;
    logic        rf_wel;
    logic [2:0]  rf_addra;
    logic [7:0]  rf_dih;
    logic [7:0]  rf_dil;
    logic [7:0]  rf_doah;
    logic [7:0]  rf_doal;

    logic        cpu_stall;
    logic        dump_req;
    logic        load_req;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;

    // Streams use valid/ready: a word moves on each rising clk edge where both
    // are high; valid never depends on ready, and an unaccepted word is held.
    logic        st_valid;
    logic        st_ready;
    logic [15:0] st_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_data;

    logic [2:0]  dbg_state;

    modport slave (
        input  cpu_cen, cpu_weh, cpu_wel, cpu_addra, cpu_dih, cpu_dil,
        output rf_cen, rf_weh, rf_wel, rf_addra, rf_dih, rf_dil,
        input  rf_doah, rf_doal,
        output cpu_stall,
        input  dump_req, load_req, abort,
        output busy, done, err,
        output st_valid, st_data,
        input  st_ready,
        input  ld_valid, ld_data,
        output ld_ready,
        output dbg_state
    );

    modport master (
        output cpu_cen, cpu_weh, cpu_wel, cpu_addra, cpu_dih, cpu_dil,
        input  rf_cen, rf_weh, rf_wel, rf_addra, rf_dih, rf_dil,
        output rf_doah, rf_doal,
        input  cpu_stall,
        output dump_req, load_req, abort,
        input  busy, done, err,
        input  st_valid, st_data,
        output st_ready,
        output ld_valid, ld_data,
        input  ld_ready,
        input  dbg_state
    );
endinterface

// File: rtl/tv80_reg_dma.sv
// Freezes the TV80 and streams its 8 register pairs out (dump) or in (load).
// The load path exists only when TV80_REG_DMA_LOAD_EN is defined.
module tv80_reg_dma (
    input logic           clk,
    input logic           reset_n,
    tv80_reg_dma_if.slave bus
);

`ifdef TV80_REG_DMA_LOAD_EN
    typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_DUMP, S_LOAD, S_DONE} state_t;
    logic op_load_q;
`else
    typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_DUMP, S_DONE} state_t;
    logic unused_ld;
    assign unused_ld = ^{bus.load_req, bus.ld_valid, bus.ld_data};
`endif

    state_t     state_q;
    logic [2:0] idx_q;
    logic       busy_q;
    logic       stall_q;
    logic       done_q;
    logic       err_q;
    logic       owned;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            busy_q  <= 1'b0;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef TV80_REG_DMA_LOAD_EN
            op_load_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    idx_q <= 3'd0;
                    if (bus.dump_req) begin
                        state_q <= S_DRAIN;
                        busy_q  <= 1'b1;
                        stall_q <= 1'b1;
`ifdef TV80_REG_DMA_LOAD_EN
                        op_load_q <= 1'b0;
                    end else if (bus.load_req) begin
                        state_q   <= S_DRAIN;
                        busy_q    <= 1'b1;
                        stall_q   <= 1'b1;
                        op_load_q <= 1'b1;
`endif
                    end
                end
                // Wait for the CPU to stop touching port A before taking it over.
                S_DRAIN: begin
                    if (bus.abort) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (!bus.cpu_cen) begin
                        err_q <= 1'b0;
                        idx_q <= 3'd0;
`ifdef TV80_REG_DMA_LOAD_EN
                        state_q <= op_load_q ? S_LOAD : S_DUMP;
`else
                        state_q <= S_DUMP;
`endif
                    end
                end
                S_DUMP: begin
                    if (bus.cpu_cen) err_q <= 1'b1;
                    if (bus.abort || (bus.st_ready && idx_q == 3'd7)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (bus.st_ready) begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
`ifdef TV80_REG_DMA_LOAD_EN
                S_LOAD: begin
                    if (bus.cpu_cen) err_q <= 1'b1;
                    if (bus.abort || (bus.ld_valid && idx_q == 3'd7)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (bus.ld_valid) begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        owned = (state_q == S_DUMP) || (state_q == S_DONE);
`ifdef TV80_REG_DMA_LOAD_EN
        owned = owned || (state_q == S_LOAD);
`endif
        bus.rf_cen   = bus.cpu_cen;
        bus.rf_weh   = bus.cpu_weh;
        bus.rf_wel   = bus.cpu_wel;
        bus.rf_addra = bus.cpu_addra;
        bus.rf_dih   = bus.cpu_dih;
        bus.rf_dil   = bus.cpu_dil;
        if (owned) begin
            bus.rf_cen   = 1'b0;
            bus.rf_weh   = 1'b0;
            bus.rf_wel   = 1'b0;
            bus.rf_addra = idx_q;
            bus.rf_dih   = 8'h00;
            bus.rf_dil   = 8'h00;
`ifdef TV80_REG_DMA_LOAD_EN
            bus.rf_dih = bus.ld_data[15:8];
            bus.rf_dil = bus.ld_data[7:0];
            if (state_q == S_LOAD && bus.ld_valid) begin
                bus.rf_cen = 1'b1;
                bus.rf_weh = 1'b1;
                bus.rf_wel = 1'b1;
            end
`endif
        end
    end

    assign bus.st_valid  = (state_q == S_DUMP);
    assign bus.st_data   = {bus.rf_doah, bus.rf_doal};
`ifdef TV80_REG_DMA_LOAD_EN
    assign bus.ld_ready  = (state_q == S_LOAD);
`else
    assign bus.ld_ready  = 1'b0;
`endif
    assign bus.busy      = busy_q;
    assign bus.cpu_stall = stall_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_tv80_reg_dma.sv
// Directed bench for tv80_reg_dma: pass-through table, dump, backpressure/abort,
// arbitration/err, and (with TV80_REG_DMA_LOAD_EN) load and mid-load reset.
module tb_tv80_reg_dma;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    tv80_reg_dma_if bus ();

    tv80_reg_dma dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Register-file model: asynchronous read, write on clk when CEN and WE.
    logic [7:0] mem_h [8];
    logic [7:0] mem_l [8];
    assign bus.rf_doah = mem_h[bus.rf_addra];
    assign bus.rf_doal = mem_l[bus.rf_addra];
    always @(posedge clk) begin
        if (bus.rf_cen && bus.rf_weh) mem_h[bus.rf_addra] <= bus.rf_dih;
        if (bus.rf_cen && bus.rf_wel) mem_l[bus.rf_addra] <= bus.rf_dil;
    end

    int checks = 0;
    int errors = 0;
    int words_cnt = 0;
    int done_cnt = 0;
    int ld_cnt = 0;
    logic [15:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stream/strobe monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.st_valid) begin
                chk("dump_rf_strobes", {29'd0, bus.rf_cen, bus.rf_weh, bus.rf_wel}, 32'd0);
                chk("dump_index", {29'd0, bus.rf_addra}, {29'd0, words_cnt[2:0]});
                if (bus.st_ready) begin
                    if (exp_q.size() != 0) begin
                        chk("st_data", {16'd0, bus.st_data}, {16'd0, exp_q.pop_front()});
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL st_extra: got word %h expected none", bus.st_data);
                    end
                    words_cnt++;
                end
            end
            if (bus.ld_ready) begin
                if (bus.ld_valid) begin
                    chk("ld_strobes", {29'd0, bus.rf_cen, bus.rf_weh, bus.rf_wel}, 32'd7);
                    chk("ld_addr", {29'd0, bus.rf_addra}, {29'd0, ld_cnt[2:0]});
                    chk("ld_wdata", {16'd0, bus.rf_dih, bus.rf_dil}, {16'd0, bus.ld_data});
                    ld_cnt++;
                end else begin
                    chk("ld_idle_strobes", {29'd0, bus.rf_cen, bus.rf_weh, bus.rf_wel}, 32'd0);
                end
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_busy_stall", {30'd0, bus.busy, bus.cpu_stall}, 32'd3);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_cen   = 1'b0;
        bus.cpu_weh   = 1'b0;
        bus.cpu_wel   = 1'b0;
        bus.cpu_addra = 3'd0;
        bus.cpu_dih   = 8'h00;
        bus.cpu_dil   = 8'h00;
        bus.dump_req  = 1'b0;
        bus.load_req  = 1'b0;
        bus.abort     = 1'b0;
        bus.st_ready  = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = 16'h0000;
    endtask

    task automatic start_op(input logic d, input logic l);
        bus.dump_req = d;
        bus.load_req = l;
        tick();
        bus.dump_req = 1'b0;
        bus.load_req = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            tick();
            n++;
        end
        chk(name, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic chk_mem(input string name, input int n, input logic [15:0] exp);
        chk(name, {16'd0, mem_h[n], mem_l[n]}, {16'd0, exp});
    endtask

    typedef struct {
        logic        cen, weh, wel;
        logic [2:0]  addr;
        logic [7:0]  dih, dil;
        logic [21:0] exp_rf;
        logic        chk_rd;
        logic [15:0] exp_rd;
    } pt_vec_t;

    function automatic pt_vec_t mk(input logic cen, input logic weh, input logic wel,
                                   input logic [2:0] addr, input logic [7:0] dih,
                                   input logic [7:0] dil, input logic chk_rd,
                                   input logic [15:0] exp_rd);
        pt_vec_t v;
        v.cen = cen; v.weh = weh; v.wel = wel; v.addr = addr; v.dih = dih; v.dil = dil;
        v.exp_rf = {cen, weh, wel, addr, dih, dil};
        v.chk_rd = chk_rd;
        v.exp_rd = exp_rd;
        return v;
    endfunction

    pt_vec_t vecs [12];

    initial begin
        int base_w;
        int base_d;
        int base_l;
        int n;
        logic v;

        vecs[0]  = mk(1, 1, 1, 3'd0, 8'h00, 8'h00, 0, 16'h0000);
        vecs[1]  = mk(1, 1, 1, 3'd1, 8'h11, 8'h01, 0, 16'h0000);
        vecs[2]  = mk(1, 1, 1, 3'd2, 8'h22, 8'h02, 0, 16'h0000);
        vecs[3]  = mk(1, 1, 1, 3'd3, 8'h33, 8'h03, 0, 16'h0000);
        vecs[4]  = mk(1, 1, 1, 3'd4, 8'h44, 8'h04, 0, 16'h0000);
        vecs[5]  = mk(1, 1, 1, 3'd5, 8'h55, 8'h05, 0, 16'h0000);
        vecs[6]  = mk(1, 1, 1, 3'd6, 8'h66, 8'h06, 0, 16'h0000);
        vecs[7]  = mk(1, 1, 1, 3'd7, 8'h77, 8'h07, 0, 16'h0000);
        vecs[8]  = mk(0, 0, 0, 3'd3, 8'h5A, 8'hA5, 1, 16'h3303);
        vecs[9]  = mk(1, 0, 0, 3'd7, 8'hC3, 8'h3C, 1, 16'h7707);
        vecs[10] = mk(1, 1, 0, 3'd6, 8'h66, 8'h99, 1, 16'h6606);
        vecs[11] = mk(0, 0, 0, 3'd6, 8'h00, 8'h00, 1, 16'h6606);

        // Reset state, with pass-through active during reset
        idle_inputs();
        bus.cpu_cen = 1'b1; bus.cpu_weh = 1'b1; bus.cpu_addra = 3'd5;
        bus.cpu_dih = 8'hAB; bus.cpu_dil = 8'hCD;
        #2;
        chk("rst_status", {26'd0, bus.busy, bus.cpu_stall, bus.done, bus.err, bus.st_valid, bus.ld_ready}, 32'd0);
        chk("rst_state", {29'd0, bus.dbg_state}, 32'd0);
        chk("rst_passthru", {10'd0, bus.rf_cen, bus.rf_weh, bus.rf_wel, bus.rf_addra, bus.rf_dih, bus.rf_dil},
            {10'd0, 1'b1, 1'b1, 1'b0, 3'd5, 8'hAB, 8'hCD});
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        // IDLE pass-through table; also preloads pair n = 16'h1100*n+n
        for (int i = 0; i < 12; i++) begin
            bus.cpu_cen = vecs[i].cen; bus.cpu_weh = vecs[i].weh; bus.cpu_wel = vecs[i].wel;
            bus.cpu_addra = vecs[i].addr; bus.cpu_dih = vecs[i].dih; bus.cpu_dil = vecs[i].dil;
            @(negedge clk);
            chk("pt_rf", {10'd0, bus.rf_cen, bus.rf_weh, bus.rf_wel, bus.rf_addra, bus.rf_dih, bus.rf_dil},
                {10'd0, vecs[i].exp_rf});
            chk("pt_idle_status", {28'd0, bus.busy, bus.cpu_stall, bus.st_valid, bus.ld_ready}, 32'd0);
            if (vecs[i].chk_rd) chk("pt_read", {16'd0, bus.rf_doah, bus.rf_doal}, {16'd0, vecs[i].exp_rd});
            @(posedge clk);
            #1;
        end
        idle_inputs();

        // Full dump with CPU still active for two DRAIN cycles
        base_w = words_cnt; base_d = done_cnt;
        for (int i = 0; i < 8; i++) exp_q.push_back(16'h1100 * i[15:0] + i[15:0]);
        bus.cpu_cen = 1'b1;
        bus.st_ready = 1'b1;
        start_op(1'b1, 1'b0);
        @(negedge clk);
        chk("drain_status", {29'd0, bus.busy, bus.cpu_stall, bus.st_valid}, 32'd6);
        tick();
        @(negedge clk);
        chk("drain_hold", {31'd0, bus.st_valid}, 32'd0);
        tick();
        bus.cpu_cen = 1'b0;
        wait_idle("dump_timeout", 30);
        chk("dump_words", words_cnt - base_w, 8);
        chk("dump_done_cnt", done_cnt - base_d, 1);
        chk("dump_q_empty", exp_q.size(), 0);
        chk("dump_end_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("dump_err", {31'd0, bus.err}, 32'd0);

        // Simultaneous requests pick dump; CEN injected mid-dump sets err only
        base_w = words_cnt; base_d = done_cnt;
        for (int i = 0; i < 8; i++) exp_q.push_back(16'h1100 * i[15:0] + i[15:0]);
        start_op(1'b1, 1'b1);
        n = 0;
        while (!bus.st_valid && n < 10) begin tick(); n++; end
        chk("arb_dump_chosen", {30'd0, bus.st_valid, bus.ld_ready}, 32'd2);
        tick();
        tick();
        bus.cpu_cen = 1'b1; bus.cpu_weh = 1'b1; bus.cpu_wel = 1'b1;
        bus.cpu_addra = 3'd0; bus.cpu_dih = 8'hFF; bus.cpu_dil = 8'hFF;
        tick();
        idle_inputs();
        bus.st_ready = 1'b1;
        @(negedge clk);
        chk("err_set", {30'd0, bus.err, bus.busy}, 32'd3);
        tick();
        wait_idle("arb_timeout", 30);
        chk("arb_words", words_cnt - base_w, 8);
        chk("arb_done_cnt", done_cnt - base_d, 1);
        chk("err_sticky", {31'd0, bus.err}, 32'd0 + 1);
        for (int i = 0; i < 8; i++) chk_mem("arb_rf_unchanged", i, 16'h1100 * i[15:0] + i[15:0]);

        // Backpressure at index 3, then abort
        base_w = words_cnt; base_d = done_cnt;
        for (int i = 0; i < 3; i++) exp_q.push_back(16'h1100 * i[15:0] + i[15:0]);
        start_op(1'b1, 1'b0);
        n = 0;
        while (words_cnt - base_w < 3 && n < 20) begin tick(); n++; end
        bus.st_ready = 1'b0;
        chk("bp_reach_idx3", words_cnt - base_w, 3);
        @(negedge clk);
        chk("err_cleared", {31'd0, bus.err}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_idx", {29'd0, bus.rf_addra}, 32'd3);
            chk("bp_hold_data", {15'd0, bus.st_valid, bus.st_data}, {15'd0, 1'b1, 16'h3303});
            @(posedge clk);
            #1;
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_done", {31'd0, bus.done}, 32'd1);
        tick();
        wait_idle("abort_timeout", 5);
        chk("abort_words", words_cnt - base_w, 3);
        chk("abort_done_cnt", done_cnt - base_d, 1);
        chk("abort_q_empty", exp_q.size(), 0);

`ifdef TV80_REG_DMA_LOAD_EN
        // Load with ld_valid toggling every cycle
        base_l = ld_cnt; base_d = done_cnt;
        start_op(1'b0, 1'b1);
        v = 1'b0;
        n = 0;
        while (bus.busy && n < 60) begin
            v = ~v;
            bus.ld_valid = v;
            bus.ld_data = 16'hA0A0 + 16'(ld_cnt - base_l);
            tick();
            n++;
        end
        bus.ld_valid = 1'b0;
        chk("load_timeout", {31'd0, bus.busy}, 32'd0);
        chk("load_accepts", ld_cnt - base_l, 8);
        chk("load_done_cnt", done_cnt - base_d, 1);
        for (int i = 0; i < 8; i++) chk_mem("load_rf", i, 16'hA0A0 + i[15:0]);

        // Reset in LOAD at index 4
        base_l = ld_cnt; base_d = done_cnt;
        start_op(1'b0, 1'b1);
        n = 0;
        while (ld_cnt - base_l < 4 && n < 20) begin
            bus.ld_valid = 1'b1;
            bus.ld_data = 16'h5500 + 16'(ld_cnt - base_l);
            tick();
            n++;
        end
        reset_n = 1'b0;
        bus.ld_valid = 1'b0;
        #1;
        chk("mid_rst_status", {28'd0, bus.busy, bus.cpu_stall, bus.ld_ready, bus.rf_cen}, 32'd0);
        chk("mid_rst_state", {29'd0, bus.dbg_state}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("mid_rst_accepts", ld_cnt - base_l, 4);
        chk("mid_rst_no_done", done_cnt - base_d, 0);
        for (int i = 0; i < 4; i++) chk_mem("mid_rst_new", i, 16'h5500 + i[15:0]);
        for (int i = 4; i < 8; i++) chk_mem("mid_rst_old", i, 16'hA0A0 + i[15:0]);
`else
        // Load path absent: load_req must be ignored
        base_l = ld_cnt;
        bus.ld_valid = 1'b1;
        bus.ld_data = 16'h1234;
        start_op(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("noload_status", {28'd0, bus.busy, bus.cpu_stall, bus.ld_ready, bus.rf_cen}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.ld_valid = 1'b0;
        chk("noload_accepts", ld_cnt - base_l, 0);
        for (int i = 0; i < 8; i++) chk_mem("noload_rf", i, 16'h1100 * i[15:0] + i[15:0]);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tv80_reg_dma.md
TV80_REG_DMA -- requirements
Module: tv80_reg_dma

Interface
REQ-001 SHALL have port clk, input, 1, single clock for all state.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have cpu_cen, cpu_weh, cpu_wel (input, 1 each), the CPU-side register-file clock enable and high/low write enables.
REQ-004 SHALL have cpu_addra (input, 3) and cpu_dih, cpu_dil (input, 8 each), the CPU-side port-A address and write data.
REQ-005 SHALL have rf_cen, rf_weh, rf_wel (output, 1 each), rf_addra (output, 3) and rf_dih, rf_dil (output, 8 each), which drive the register-file port A.
REQ-006 SHALL have rf_doah, rf_doal (input, 8 each), the register-file port-A read data.
REQ-007 SHALL have cpu_stall (output, 1), a freeze request to the CPU clock-enable generator.
REQ-008 SHALL have dump_req, load_req and abort (input, 1 each), single-cycle command strobes.
REQ-009 SHALL have busy, done and err (output, 1 each): operation active, completion pulse and sticky CEN-while-owned flag.
REQ-010 SHALL have st_valid (output, 1), st_ready (input, 1) and st_data (output, 16), the dump stream, data = {H,L}.
REQ-011 SHALL have ld_valid (input, 1), ld_ready (output, 1) and ld_data (input, 16), the load stream, data = {H,L}.

Function
REQ-012 SHALL implement states IDLE, DRAIN, DUMP, LOAD, DONE.
REQ-013 In IDLE, rf_* SHALL pass the cpu_* signals through combinationally, and cpu_stall, busy, st_valid and ld_ready SHALL be 0.
REQ-014 In IDLE, dump_req or load_req SHALL latch the operation type, set busy and cpu_stall, and go to DRAIN next cycle; dump_req SHALL win if both are asserted together.
REQ-015 Command strobes outside IDLE SHALL be ignored.
REQ-016 DRAIN SHALL keep the CPU pass-through and move to DUMP or LOAD on the first cycle cpu_cen is sampled 0; the entry cycle SHALL clear err and set the 3-bit index to 0.
REQ-017 In DUMP, LOAD and DONE, the block SHALL own port A: rf_addra = index, and the CPU strobes SHALL be discarded.
REQ-018 In DUMP, rf_cen, rf_weh and rf_wel SHALL be 0, st_valid SHALL be 1, and st_data SHALL be {rf_doah, rf_doal} combinationally.
REQ-019 In DUMP, the index SHALL advance on each st_valid&&st_ready, and the transfer at index 7 SHALL go to DONE.
REQ-020 In LOAD, ld_ready SHALL be 1, and on ld_valid&&ld_ready rf_cen, rf_weh and rf_wel SHALL be 1 with rf_dih = ld_data[15:8] and rf_dil = ld_data[7:0] in that same cycle; otherwise the write strobes SHALL be 0.
REQ-021 In LOAD, the index SHALL advance on each accepted word, and the word at index 7 SHALL go to DONE.
REQ-022 Exactly 8 transfers SHALL occur per operation (index 0..7, no wrap); a stalled handshake SHALL hold the index indefinitely.
REQ-023 DONE SHALL last one cycle with done=1 and cpu_stall=1, then go to IDLE with busy and cpu_stall cleared.
REQ-024 abort in DRAIN, DUMP or LOAD SHALL go to DONE next cycle; words already loaded SHALL remain written; abort in IDLE or DONE SHALL be ignored.
REQ-025 cpu_cen=1 while in DUMP or LOAD SHALL set err; the operation SHALL continue.

Reset
REQ-026 reset_n low SHALL asynchronously force IDLE, index 0 and operation type dump, with cpu_stall, busy, done, err, st_valid and ld_ready all 0.
REQ-027 Reset mid-operation SHALL abandon it silently: no done pulse, and partial loads remain in the register file.
REQ-028 rf_* SHALL follow cpu_* immediately during reset.

Configuration
REQ-029 Macro TV80_REG_DMA_LOAD_EN SHALL gate the load path.
REQ-030 With TV80_REG_DMA_LOAD_EN defined, LOAD and the ld_* handshake SHALL behave as specified above.
REQ-031 Without TV80_REG_DMA_LOAD_EN, load_req SHALL be ignored, ld_ready SHALL be tied 0, rf_weh and rf_wel in owned states SHALL be tied 0, and the LOAD state SHALL be removed.

Verification
REQ-032 Dump: RF preloaded pair n = 16'h1100*n+n, dump_req, cpu_cen low after 2 cycles, st_ready=1 -> 8 words 0000, 1101, ..., 7707, then done pulse, busy and cpu_stall low next cycle.
REQ-033 Load with gaps: load_req, ld_valid toggling 1/0, data 16'hA0A0+n -> RF pair n = A0A0+n for all n, one done pulse after the 8th accept.
REQ-034 Backpressure and abort: dump with st_ready=0 for 5 cycles at index 3 -> index and st_data held; then abort -> done next cycle, only 3 words transferred.
REQ-035 Arbitration and err: dump_req and load_req in the same cycle -> dump performed; cpu_cen=1 injected in DUMP -> err=1, RF unchanged, err cleared at the next DRAIN exit.
REQ-036 Reset: reset_n low mid-LOAD at index 4 -> IDLE immediately, pairs 0-3 new, 4-7 old, done never asserted.
REQ-037 Config: build without TV80_REG_DMA_LOAD_EN, load_req -> busy stays 0, RF untouched.
